// File: rtl/id_scanner_if.sv
// Character-stream and token-report bundle for id_scanner.
// The master drives characters in; the slave (the scanner) reports tokens.
// LEN_W must equal $clog2(MAX_LEN+1) of the attached scanner.
interface id_scanner_if #(
    parameter int CHAR_W = 8,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 16
);
    logic [CHAR_W-1:0] char;
    logic              char_valid;
    logic              flush;
    logic              out;
    logic              tok_valid;
    logic [LEN_W-1:0]  tok_len;
    logic              tok_ovf;
    logic [CNT_W-1:0]  tok_count;

    modport master (
        output char, char_valid, flush,
        input  out, tok_valid, tok_len, tok_ovf, tok_count
    );

    modport slave (
        input  char, char_valid, flush,
        output out, tok_valid, tok_len, tok_ovf, tok_count
    );
endinterface

// File: rtl/id_scanner.sv
// Streaming identifier tokenizer.
// Classifies one character per accepted cycle, tracks whether the current
// token is a legal identifier (letter then letters/digits) and, when an
// identifier ends (delimiter or flush), reports its saturated length, an
// overflow flag and a running identifier count.
// Optional feature macro: ID_UNDERSCORE_EN -- when defined, '_' counts as a
// letter; otherwise it is a delimiter.
module id_scanner #(
    parameter int  CHAR_W  = 8,
    parameter int  MAX_LEN = 16,
    parameter int  CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input logic         clk,
    input logic         rst,
    id_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IDENT = 2'd1,
        BAD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CL_DELIM  = 2'd0,
        CL_LETTER = 2'd1,
        CL_DIGIT  = 2'd2
    } cls_t;

    // Any character with bits above bit 6 set falls outside every range
    // below, so it classifies as a delimiter without a separate test.
    function automatic cls_t classify(input logic [CHAR_W-1:0] c);
        cls_t r;
        r = CL_DELIM;
        if ((c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) ||
            (c >= CHAR_W'(8'h61) && c <= CHAR_W'(8'h7A)))
            r = CL_LETTER;
        else if (c >= CHAR_W'(8'h30) && c <= CHAR_W'(8'h39))
            r = CL_DIGIT;
`ifdef ID_UNDERSCORE_EN
        if (c == CHAR_W'(8'h5F))
            r = CL_LETTER;
`else
        // '_' stays a delimiter, so "a_b" splits into two identifiers.
`endif
        return r;
    endfunction

    function automatic logic at_max(input logic [LEN_W-1:0] v);
        return (v == LEN_W'(MAX_LEN));
    endfunction

    // Length counter that sticks at MAX_LEN.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return at_max(v) ? v : v + LEN_W'(1);
    endfunction

    state_t           state_p0, state_p1;
    cls_t             cls_p0;
    logic [LEN_W-1:0] len_p0, len_p1;
    logic             ovf_p0, ovf_p1;
    logic             emit_p0;
    logic [LEN_W-1:0] emit_len_p0;
    logic             emit_ovf_p0;

    logic             out_p1;
    logic             tok_valid_p1;
    logic [LEN_W-1:0] tok_len_p1;
    logic             tok_ovf_p1;
    logic [CNT_W-1:0] tok_count_p1;

    // ---- stage p0: classify the character, compute next state and emit ----
    // Next-state / token bookkeeping: the character is applied first, then flush ends the token.
    always_comb begin
        state_d_defaults: begin
            state_p0    = state_p1;
            len_p0      = len_p1;
            ovf_p0      = ovf_p1;
            emit_p0     = 1'b0;
            emit_len_p0 = len_p1;
            emit_ovf_p0 = ovf_p1;
            cls_p0      = classify(bus.char);
        end

        if (bus.char_valid) begin
            case (state_p1)
                IDLE: begin
                    if (cls_p0 == CL_LETTER) begin
                        state_p0 = IDENT;
                        len_p0   = LEN_W'(1);
                        ovf_p0   = 1'b0;
                    end else if (cls_p0 == CL_DIGIT) begin
                        state_p0 = BAD;
                    end
                end
                IDENT: begin
                    if (cls_p0 != CL_DELIM) begin
                        ovf_p0 = ovf_p1 | at_max(len_p1);
                        len_p0 = sat_inc(len_p1);
                    end else begin
                        emit_p0  = 1'b1;
                        state_p0 = IDLE;
                    end
                end
                BAD: begin
                    if (cls_p0 == CL_DELIM)
                        state_p0 = IDLE;
                end
                default: state_p0 = IDLE;
            endcase
        end

        if (bus.flush) begin
            if (state_p0 == IDENT)
                emit_p0 = 1'b1;
            state_p0 = IDLE;
        end

        // The reported length is the token as it stands after this character;
        // a delimiter never advanced it, so it is not counted.
        emit_len_p0 = len_p0;
        emit_ovf_p0 = ovf_p0;
        if (emit_p0) begin
            len_p0 = '0;
            ovf_p0 = 1'b0;
        end
    end

    // ---- stage p1: registered state and token outputs ----
    // FSM state register; reset drops any partial token.
    always_ff @(posedge clk) begin
        if (rst)
            state_p1 <= IDLE;
        else
            state_p1 <= state_p0;
    end

    // Running length/overflow of the current token; only meaningful in IDENT.
    always_ff @(posedge clk) begin
        len_p1 <= len_p0;
        ovf_p1 <= ovf_p0;
    end

    // Token report registers: pulse on emit, hold length/flag otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1       <= 1'b0;
            tok_valid_p1 <= 1'b0;
            tok_len_p1   <= '0;
            tok_ovf_p1   <= 1'b0;
            tok_count_p1 <= '0;
        end else begin
            out_p1       <= (state_p0 == IDENT);
            tok_valid_p1 <= emit_p0;
            if (emit_p0) begin
                tok_len_p1   <= emit_len_p0;
                tok_ovf_p1   <= emit_ovf_p0;
                tok_count_p1 <= tok_count_p1 + CNT_W'(1);
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.tok_valid = tok_valid_p1;
    assign bus.tok_len   = tok_len_p1;
    assign bus.tok_ovf   = tok_ovf_p1;
    assign bus.tok_count = tok_count_p1;

endmodule

// File: tb/tb_id_scanner.sv
// Bench for id_scanner: token-level reference model plus directed scenarios.
module tb_id_scanner;
    localparam int CHAR_W  = 8;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_scanner_if #(.CHAR_W(CHAR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    id_scanner #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_emit = 0;
    bit armed  = 0;

    // Reference model: the token is a list of non-delimiter characters.
    bit m_in = 0, m_id = 0;
    int m_cnt = 0;
    bit m_out = 0, m_tv = 0, m_ovf = 0;
    int m_len = 0;
    int m_count = 0;

    function automatic bit is_letter(input logic [7:0] c);
        bit r;
        r = (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
`ifdef ID_UNDERSCORE_EN
        if (c == "_") r = 1;
`endif
        return r;
    endfunction

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= "0" && c <= "9");
    endfunction

    task automatic m_end();
        if (m_in && m_id) begin
            m_tv    = 1;
            m_len   = (m_cnt > MAX_LEN) ? MAX_LEN : m_cnt;
            m_ovf   = (m_cnt > MAX_LEN);
            m_count = (m_count + 1) % (1 << CNT_W);
        end
        m_in = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_in = 0; m_id = 0; m_cnt = 0;
            m_out = 0; m_tv = 0; m_len = 0; m_ovf = 0; m_count = 0;
        end else begin
            m_tv = 0;
            if (bus.char_valid) begin
                if (!is_letter(bus.char) && !is_digit(bus.char)) begin
                    m_end();
                end else if (!m_in) begin
                    m_in  = 1;
                    m_id  = is_letter(bus.char);
                    m_cnt = 1;
                end else begin
                    m_cnt++;
                end
            end
            if (bus.flush) m_end();
            m_out = m_in && m_id;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("out",       32'(bus.out),       32'(m_out));
            chk("tok_valid", 32'(bus.tok_valid), 32'(m_tv));
            chk("tok_len",   32'(bus.tok_len),   32'(m_len));
            chk("tok_ovf",   32'(bus.tok_ovf),   32'(m_ovf));
            chk("tok_count", 32'(bus.tok_count), 32'(m_count));
            if (bus.tok_valid === 1'b1) n_emit++;
        end
    end

    task automatic step(input logic [7:0] c, input logic v, input logic f);
        bus.char       = c;
        bus.char_valid = v;
        bus.flush      = f;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic put(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        n_emit = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.char = '0; bus.char_valid = 1'b0; bus.flush = 1'b0;
        do_reset();
        armed = 1;
        step(8'h00, 1'b0, 1'b0);
        chk("reset_count", 32'(bus.tok_count), 0);
        chk("reset_out",   32'(bus.out),       0);

        // 1: "ab12 " -> one identifier of length 4
        step("a", 1'b1, 1'b0);
        chk("t1_out_after_a", 32'(bus.out), 1);
        put("b12 ");
        step(8'h00, 1'b0, 1'b0);
        chk("t1_emits", n_emit, 1);
        chk("t1_len",   32'(bus.tok_len),   4);
        chk("t1_ovf",   32'(bus.tok_ovf),   0);
        chk("t1_count", 32'(bus.tok_count), 1);

        // 2: "1ab c " -> only "c"; flush in IDLE and in BAD emits nothing
        do_reset();
        put("1ab c ");
        step(8'h00, 1'b0, 1'b1);
        put("9x");
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        chk("t2_emits", n_emit, 1);
        chk("t2_len",   32'(bus.tok_len),   1);
        chk("t2_count", 32'(bus.tok_count), 1);

        // 3: saturation at MAX_LEN=8, exact boundary and over it
        do_reset();
        for (int i = 0; i < 8; i++) step("y", 1'b1, 1'b0);
        step(" ", 1'b1, 1'b0);
        chk("t3_len8",  32'(bus.tok_len), 8);
        chk("t3_ovf8",  32'(bus.tok_ovf), 0);
        for (int i = 0; i < 10; i++) step("z", 1'b1, 1'b0);
        step(" ", 1'b1, 1'b0);
        chk("t3_len10", 32'(bus.tok_len), 8);
        chk("t3_ovf10", 32'(bus.tok_ovf), 1);
        put("q ");
        chk("t3_len_q", 32'(bus.tok_len), 1);
        chk("t3_ovf_q", 32'(bus.tok_ovf), 0);

        // 4: reset mid-token discards it
        do_reset();
        put("ab");
        do_reset();
        put(" ");
        step(8'h00, 1'b0, 1'b0);
        chk("t4_emits", n_emit, 0);
        chk("t4_count", 32'(bus.tok_count), 0);
        chk("t4_len",   32'(bus.tok_len),   0);
        chk("t4_out",   32'(bus.out),       0);

        // 5: flush alone, flush with char, gaps mid-token
        do_reset();
        step("x", 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step("y", 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1);
        chk("t5_len_flush", 32'(bus.tok_len), 2);
        step("k", 1'b1, 1'b1);
        chk("t5_len_kflush", 32'(bus.tok_len), 1);
        chk("t5_tv_kflush",  32'(bus.tok_valid), 1);
        put("ab");
        step(" ", 1'b1, 1'b1);
        chk("t5_len_delimflush", 32'(bus.tok_len), 2);
        put("a");
        step(8'hC1, 1'b1, 1'b0);
        chk("t5_len_hibit", 32'(bus.tok_len), 1);
        chk("t5_count", 32'(bus.tok_count), 4);

        // 6: underscore handling
        do_reset();
        put("a_b ");
        step(8'h00, 1'b0, 1'b0);
`ifdef ID_UNDERSCORE_EN
        chk("t6_emits", n_emit, 1);
        chk("t6_len",   32'(bus.tok_len), 3);
`else
        chk("t6_emits", n_emit, 2);
        chk("t6_len",   32'(bus.tok_len), 1);
`endif

        // 7: back-to-back emits and count wrap (CNT_W=4)
        do_reset();
        for (int i = 0; i < 17; i++) step("a", 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        chk("t7_emits", n_emit, 17);
        chk("t7_count", 32'(bus.tok_count), 1);

        step(8'h00, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
